fb_port_arbiter: RTL
====================

# fb_port_arbiter

Shares the single-port frame-buffer RAM between the VGA scanout path and the renderer's pixel-write channel. Scanout reads always win the RAM slot. Renderer writes are buffered in a 4-entry FIFO and drained in free cycles:
- during blanking;
- while the scanout address repeats, since each RAM pixel spans several screen pixels.

The block sits between the renderer, the VGA timing/output block and the frame-buffer RAM.

## Interface
Parameters:
- AW, 14, RAM address width, {row[6:0], col[6:0]}
- DW, 12, pixel width, {b[3:0], g[3:0], r[3:0]}
- DEPTH, 4, write FIFO entries (power of two)

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge
- clrn  in  1  reset, asynchronous, active-low
- scan_active  in  1  scanout window active, registered by the VGA block
- scan_addr  in  AW  scanout pixel address {row_addr, col_addr}
- scan_data  out  DW  pixel data returned to the VGA block
- wr_valid  in  1  renderer write request
- wr_ready  out  1  FIFO can accept a write
- wr_addr  in  AW  write address
- wr_data  in  DW  write pixel
- ram_addr  out  AW  RAM address (combinational from grant)
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid one cycle after address (synchronous read)
- fifo_level  out  3  entries currently buffered, 0..DEPTH
- stall_cnt  out  16  saturating count of cycles with wr_valid && !wr_ready

## Operation
- Cache tag: last_addr (AW) and last_valid (1) record the last scanout address read from RAM.
- Per-cycle grant, highest priority first:
  - SCAN: scan_active && (!last_valid || scan_addr != last_addr). Drive ram_addr=scan_addr, ram_we=0. Set last_addr<=scan_addr, last_valid<=1 and rd_pend<=1.
  - WRITE: FIFO non-empty. Drive ram_addr/ram_wdata from the FIFO head, ram_we=1, and pop. If the head address == last_addr, clear last_valid so the next active cycle re-reads.
  - IDLE: ram_addr=scan_addr, ram_we=0.
- A SCAN grant takes priority when a pending write targets last_addr. The write is applied in a later free cycle; clearing last_valid at that point forces a re-read.
- Read return: when rd_pend is set, scan_data<=ram_rdata on the next edge. Otherwise scan_data holds.
- Falling edge of scan_active: last_valid<=0. scan_data holds.
- FIFO:
  - Push when wr_valid && wr_ready.
  - wr_ready = (level != DEPTH), from registered level.
  - Push and pop in the same cycle: level unchanged.
  - There is no bypass. An accepted write reaches RAM at the earliest one cycle after acceptance.
  - Writes drain in acceptance order.
- stall_cnt increments on each cycle with wr_valid && !wr_ready and saturates at 16'hFFFF.
- Width rules:
  - Address compare is full AW bits.
  - level is a DEPTH+1 range counter.
  - FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset (async assert, sync release):
  - scan_data=0, wr_ready=1 (level 0 after reset), fifo_level=0, stall_cnt=0, rd_pend=0, last_valid=0, FIFO pointers 0.
  - ram_we=0 combinationally, since the FIFO is empty.
- Reset mid-operation: buffered writes are discarded and never reach RAM. A pending read return is discarded.
- Scanout latency: scan_addr new in cycle t → RAM read in t → scan_data updated at edge ending t+1 (visible in t+2).
- Repeated scan_addr: no RAM read; scan_data unchanged.
- Write latency with the RAM idle: wr_valid accepted at edge e → ram_we=1 in the cycle after e.
- Worst-case drain: bounded by the number of non-SCAN cycles. During continuous distinct-address scanout, no write issues.

## Test plan
- Reset → scan_data=0, fifo_level=0, wr_ready=1, stall_cnt=0, ram_we=0.
- Active scan with address sequence 0x0000 ×8, then 0x0001 ×8; RAM holds 0xABC / 0x123 → exactly one read per address; scan_data=0xABC two cycles after the first address, 0x123 two cycles after the change.
- scan_active=0; push 4 writes (addr 0x10..0x13, data 0x111..0x444) → each written on consecutive cycles in order; fifo_level peaks at 1.
- scan_active=1 with a new address every cycle; push 5 writes → wr_ready=0 after 4 accepted; stall_cnt increments per stalled cycle; no ram_we until the scan address repeats.
- Scan sitting on address 0x0005 (cached 0x0AA); write 0x0005←0xFFF → write issued, last_valid cleared, re-read next cycle, scan_data=0xFFF two cycles later.
- Assert clrn low with 3 writes buffered → fifo_level=0 immediately; after release, no ram_we occurs with stale data.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares the single-port frame-buffer RAM between VGA scanout reads and
//   renderer pixel writes. Scanout always wins the RAM slot; renderer writes
//   are buffered in a small FIFO and drained whenever the slot is free
//   (blanking, or while the scanout address repeats because one RAM pixel
//   covers several screen pixels).
//
// Ports
//   vga_clk, clrn        pixel clock, async active-low reset
//   scan_active          scanout window active
//   scan_addr            scanout pixel address {row, col}
//   scan_data            pixel returned to the VGA block
//   wr_valid/wr_ready    renderer write handshake
//   wr_addr, wr_data     renderer write address / pixel
//   ram_addr, ram_we,    RAM port (combinational from the grant)
//   ram_wdata, ram_rdata (ram_rdata valid one cycle after ram_addr)
//   fifo_level           entries currently buffered
//   stall_cnt            saturating count of cycles wr_valid && !wr_ready

module fb_port_arbiter #(
   parameter int unsigned AW    = 14,
   parameter int unsigned DW    = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic          vga_clk,
   input  logic          clrn,
   input  logic          scan_active,
   input  logic [AW-1:0] scan_addr,
   output logic [DW-1:0] scan_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic [2:0]    fifo_level,
   output logic [15:0]   stall_cnt
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {GntIdle, GntScan, GntWrite} gnt_e;

   gnt_e gnt;

   // Cache tag of the last scanout address actually read from RAM
   logic [AW-1:0] last_addr_q, last_addr_d;
   logic          last_valid_q, last_valid_d;
   logic          rd_pend_q;
   logic [DW-1:0] scan_data_q, scan_data_d;

   // Write FIFO
   logic [AW-1:0] fifo_addr_q [DEPTH];
   logic [DW-1:0] fifo_data_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic [15:0]   stall_q, stall_d;
   logic          push, pop;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;

   assign head_addr = fifo_addr_q[rd_ptr_q];
   assign head_data = fifo_data_q[rd_ptr_q];

   assign wr_ready   = (level_q != LW'(DEPTH));
   assign push       = wr_valid && wr_ready;
   assign pop        = (gnt == GntWrite);
   assign fifo_level = 3'(level_q);
   assign stall_cnt  = stall_q;
   assign scan_data  = scan_data_q;

   // Grant: a scanout read only when the address is not already cached
   always_comb begin
      gnt = GntIdle;
      if (scan_active && (!last_valid_q || (scan_addr != last_addr_q))) begin
         gnt = GntScan;
      end else if (level_q != '0) begin
         gnt = GntWrite;
      end
   end

   always_comb begin
      ram_addr  = scan_addr;
      ram_we    = 1'b0;
      ram_wdata = head_data;
      unique case (gnt)
         GntScan:  ram_addr = scan_addr;
         GntWrite: begin
            ram_addr = head_addr;
            ram_we   = 1'b1;
         end
         GntIdle:  ram_addr = scan_addr;
         default:  ram_addr = scan_addr;
      endcase
   end

   always_comb begin
      last_addr_d  = last_addr_q;
      last_valid_d = last_valid_q;
      if (gnt == GntScan) begin
         last_addr_d  = scan_addr;
         last_valid_d = 1'b1;
      end else begin
         // Leaving the active window invalidates the cache; holding it
         // cleared while inactive is equivalent since no read happens then.
         if (!scan_active) last_valid_d = 1'b0;
         // A write landing on the cached pixel forces a re-read
         if ((gnt == GntWrite) && (head_addr == last_addr_q)) last_valid_d = 1'b0;
      end
   end

   always_comb begin
      scan_data_d = rd_pend_q ? ram_rdata : scan_data_q;

      level_d = level_q;
      if (push && !pop) level_d = level_q + LW'(1);
      else if (!push && pop) level_d = level_q - LW'(1);

      stall_d = stall_q;
      if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         last_addr_q  <= '0;
         last_valid_q <= 1'b0;
         rd_pend_q    <= 1'b0;
         scan_data_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         stall_q      <= '0;
      end else begin
         last_addr_q  <= last_addr_d;
         last_valid_q <= last_valid_d;
         rd_pend_q    <= (gnt == GntScan);
         scan_data_q  <= scan_data_d;
         level_q      <= level_d;
         stall_q      <= stall_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // FIFO storage needs no reset; the level counter guards every read
   always_ff @(posedge vga_clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= wr_addr;
         fifo_data_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule
